// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the RV32 core: owns the PC and the IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets fault and halt fetch.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 1024,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        halted,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);

   localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

   logic [31:0] pc_p0;
   logic        vld_p1;
   logic [31:0] inst_p1;
   logic [31:0] pc_p1;
   logic [31:0] pc4_p1;
   logic        halted_q;
   logic        fault_q;
   logic [31:0] fault_pc_q;
   logic        fetch_ok;
   logic        misaligned;

   // Whole word must lie inside memory; 33-bit sum so PCs near 2^32 cannot wrap in.
   function automatic logic pc_in_range(input logic [31:0] pc);
      logic [32:0] last_byte;
      last_byte = {1'b0, pc} + 33'd3;
      return last_byte < IMEM_LIMIT;
   endfunction

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = |redirect_pc[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign fetch_ok = pc_in_range(pc_p0);

   // Stage p0 -> p1: PC update and IF/ID capture
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p0      <= RESET_PC;
         vld_p1     <= 1'b0;
         inst_p1    <= NOP_INST;
         pc_p1      <= 32'h0;
         pc4_p1     <= 32'h0;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
      end else if (redirect_valid) begin
         pc_p0    <= misaligned ? redirect_pc : {redirect_pc[31:2], 2'b00};
         vld_p1   <= 1'b0;
         inst_p1  <= NOP_INST;
         halted_q <= misaligned;
         if (misaligned) begin
            fault_q <= 1'b1;
            if (!fault_q) fault_pc_q <= redirect_pc;
         end
      end else if (halted_q) begin
         vld_p1  <= 1'b0;
         inst_p1 <= NOP_INST;
      end else if (!stall) begin
         if (fetch_ok) begin
            inst_p1 <= imem_data;
            pc_p1   <= pc_p0;
            pc4_p1  <= pc_p0 + 32'd4;
            vld_p1  <= 1'b1;
            pc_p0   <= pc_p0 + 32'd4;
         end else begin
            vld_p1   <= 1'b0;
            inst_p1  <= NOP_INST;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
            if (!fault_q) fault_pc_q <= pc_p0;
         end
      end
   end

   assign imem_addr   = pc_p0;
   assign id_valid    = vld_p1;
   assign id_inst     = inst_p1;
   assign id_pc       = pc_p1;
   assign id_pc_plus4 = pc4_p1;
   assign halted      = halted_q;
   assign fetch_fault = fault_q;
   assign fault_pc    = fault_pc_q;

endmodule
